irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller. It snoops CPU RAM writes for mask load, acknowledge
// and end-of-interrupt, and presents one prioritised request at a time.
module irq_ctrl #(
   parameter logic [13:0] MASK_ADDR = 14'h3FF0,
   parameter logic [13:0] EOI_ADDR  = 14'h3FF1,
   parameter logic [13:0] ACK_ADDR  = 14'h0006,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  irq_src_i,
   input  logic        wr_en_i,
   input  logic [13:0] addr_to_ram_i,
   input  logic [31:0] data_to_ram_i,
   output logic        interrupt_o,
   output logic [1:0]  irq_id_o,
   output logic [3:0]  mask_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;
   localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

   logic [3:0] sync1_q, sync2_q, sync3_q;
   logic [1:0] arm_q;
   logic [3:0] pending_q, pending_d;
   logic [3:0] mask_q, mask_d;
   logic [1:0] state_q, state_d;
   logic [1:0] irq_id_q, irq_id_d;
   logic [7:0] wait_q, wait_d;
   logic       interrupt_q, interrupt_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;

   logic [3:0] rise, clr, active;
   logic       mask_wr, ack_wr, eoi_wr;
   logic       unused_data;

   assign unused_data = ^data_to_ram_i[31:4];

   // Edges are ignored until the third flop holds a sampled input, so a level
   // already high when reset releases never looks like a fresh edge.
   assign rise    = (arm_q == 2'd3) ? (sync2_q & ~sync3_q) : 4'b0000;
   assign mask_wr = wr_en_i && (addr_to_ram_i == MASK_ADDR);
   assign ack_wr  = wr_en_i && (addr_to_ram_i == ACK_ADDR);
   assign eoi_wr  = wr_en_i && (addr_to_ram_i == EOI_ADDR);
   assign active  = pending_q & mask_q;

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      wait_d   = wait_q;
      err_d    = err_q;
      clr      = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (|active) begin
               state_d = ST_REQ;
               wait_d  = 8'd0;
               for (int i = 3; i >= 0; i--) begin
                  if (active[i]) irq_id_d = 2'(i);
               end
            end
         end
         ST_REQ: begin
            if (ack_wr) begin
               clr[irq_id_q] = 1'b1;
               state_d       = ST_SERVICE;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         ST_SERVICE: begin
            if (eoi_wr) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new edge arriving with its acknowledge keeps the pending bit set.
   assign pending_d   = (pending_q & ~clr) | rise;
   assign mask_d      = mask_wr ? data_to_ram_i[3:0] : mask_q;
   assign interrupt_d = (state_d == ST_REQ);
   assign busy_d      = (state_d != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 4'b0000;
         sync2_q     <= 4'b0000;
         sync3_q     <= 4'b0000;
         arm_q       <= 2'd0;
         pending_q   <= 4'b0000;
         mask_q      <= 4'h0;
         state_q     <= ST_IDLE;
         irq_id_q    <= 2'd0;
         wait_q      <= 8'd0;
         interrupt_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync1_q     <= irq_src_i;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         state_q     <= state_d;
         irq_id_q    <= irq_id_d;
         wait_q      <= wait_d;
         interrupt_q <= interrupt_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign interrupt_o = interrupt_q;
   assign irq_id_o    = irq_id_q;
   assign mask_o      = mask_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven bench for irq_ctrl: per-cycle vectors with expected outputs go through a
// scoreboard queue, followed by hand-written corner sequences around reset.
module tb_irq_ctrl;

   localparam logic [13:0] MA = 14'h3FF0;
   localparam logic [13:0] EA = 14'h3FF1;
   localparam logic [13:0] AA = 14'h0006;

   typedef struct {
      logic [3:0]  irq;
      logic        wr;
      logic [13:0] addr;
      logic [31:0] data;
      int          rep;
      logic        e_int;
      logic        e_busy;
      logic [1:0]  e_id;
      logic [3:0]  e_mask;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic       intr;
      logic       busy;
      logic [1:0] id;
      logic [3:0] mask;
      logic       err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  irq_src;
   logic        wr_en;
   logic [13:0] addr_to_ram;
   logic [31:0] data_to_ram;
   logic        interrupt;
   logic [1:0]  irq_id;
   logic [3:0]  mask;
   logic        busy;
   logic        err;

   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb_q[$];
   vec_t tbl[$];

   irq_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irq_src_i     (irq_src),
      .wr_en_i       (wr_en),
      .addr_to_ram_i (addr_to_ram),
      .data_to_ram_i (data_to_ram),
      .interrupt_o   (interrupt),
      .irq_id_o      (irq_id),
      .mask_o        (mask),
      .busy_o        (busy),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [3:0] irq, input logic wr, input logic [13:0] addr,
                               input logic [31:0] data, input int rep, input logic e_int,
                               input logic e_busy, input logic [1:0] e_id,
                               input logic [3:0] e_mask, input logic e_err);
      vec_t v;
      v.irq = irq; v.wr = wr; v.addr = addr; v.data = data; v.rep = rep;
      v.e_int = e_int; v.e_busy = e_busy; v.e_id = e_id; v.e_mask = e_mask; v.e_err = e_err;
      return v;
   endfunction

   function automatic exp_t ex(input logic e_int, input logic e_busy, input logic [1:0] e_id,
                               input logic [3:0] e_mask, input logic e_err);
      exp_t e;
      e.intr = e_int; e.busy = e_busy; e.id = e_id; e.mask = e_mask; e.err = e_err;
      return e;
   endfunction

   task automatic check(input string name);
      exp_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_miss++;
         $display("FAIL %s: no expected entry in scoreboard", name);
         return;
      end
      e = sb_q.pop_front();
      if (interrupt !== e.intr || busy !== e.busy || irq_id !== e.id ||
          mask !== e.mask || err !== e.err) begin
         n_miss++;
         $display("FAIL %s: got int=%0b busy=%0b id=%0d mask=%h err=%0b, want int=%0b busy=%0b id=%0d mask=%h err=%0b",
                  name, interrupt, busy, irq_id, mask, err,
                  e.intr, e.busy, e.id, e.mask, e.err);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      for (int r = 0; r < v.rep; r++) begin
         @(negedge clk);
         irq_src     = v.irq;
         wr_en       = v.wr;
         addr_to_ram = v.addr;
         data_to_ram = v.data;
         sb_q.push_back(ex(v.e_int, v.e_busy, v.e_id, v.e_mask, v.e_err));
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d]", tag, r));
      end
   endtask

   initial begin
      // Fields: irq, wr, addr, data, rep | int, busy, id, mask, err
      // Single source, full handshake; only data[3:0] loads the mask.
      tbl.push_back(mk(4'h0, 1, MA, 32'hABCD_123F, 1, 0, 0, 2'd0, 4'hF, 0));
      tbl.push_back(mk(4'h4, 0, 0, 0, 1, 0, 0, 2'd0, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd0, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, AA, 32'h0000_1234, 1, 0, 1, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 0, 1, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, EA, 32'hDEAD_BEEF, 1, 0, 0, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 0, 0, 2'd2, 4'hF, 0));
      // Two simultaneous sources: priority, re-request after one IDLE cycle, stray writes.
      tbl.push_back(mk(4'hA, 0, 0, 0, 1, 0, 0, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd2, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd1, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd1, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd1, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd3, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd3, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd3, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd3, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd3, 4'hF, 0));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 0, 2'd3, 4'hF, 0));
      // Masked source is held, released by a mask write; mask change in REQ does not withdraw.
      tbl.push_back(mk(4'h0, 1, MA, 32'h0, 1, 0, 0, 2'd3, 4'h0, 0));
      tbl.push_back(mk(4'h1, 0, 0, 0, 1, 0, 0, 2'd3, 4'h0, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 4, 0, 0, 2'd3, 4'h0, 0));
      tbl.push_back(mk(4'h0, 1, MA, 32'h1, 1, 0, 0, 2'd3, 4'h1, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd0, 4'h1, 0));
      tbl.push_back(mk(4'h0, 1, MA, 32'h0, 1, 1, 1, 2'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd0, 4'h0, 0));
      tbl.push_back(mk(4'h0, 1, MA, 32'hF, 1, 0, 0, 2'd0, 4'hF, 0));
      // Acknowledge timeout: 16 cycles in REQ, err, one IDLE cycle, re-request.
      tbl.push_back(mk(4'h2, 0, 0, 0, 1, 0, 0, 2'd0, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd0, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 16, 1, 1, 2'd1, 4'hF, 0));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 0, 0, 2'd1, 4'hF, 1));
      tbl.push_back(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd1, 4'hF, 1));
      tbl.push_back(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd1, 4'hF, 1));
      tbl.push_back(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd1, 4'hF, 1));

      rst_n = 1'b0; irq_src = 4'h0; wr_en = 1'b0; addr_to_ram = '0; data_to_ram = '0;
      repeat (2) @(posedge clk);
      #1;
      sb_q.push_back(ex(0, 0, 2'd0, 4'h0, 0));
      check("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // A new edge on source 0 lands on the same edge as its acknowledge: it must stay pending.
      apply(mk(4'h1, 0, 0, 0, 1, 0, 0, 2'd1, 4'hF, 1), "setwin_a");
      apply(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd1, 4'hF, 1), "setwin_b");
      apply(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd0, 4'hF, 1), "setwin_req");
      apply(mk(4'h1, 0, 0, 0, 1, 1, 1, 2'd0, 4'hF, 1), "setwin_c");
      apply(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd0, 4'hF, 1), "setwin_d");
      apply(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd0, 4'hF, 1), "setwin_ack");
      apply(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd0, 4'hF, 1), "setwin_eoi");
      apply(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd0, 4'hF, 1), "setwin_rereq");
      apply(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd0, 4'hF, 1), "setwin_ack2");
      apply(mk(4'h0, 1, EA, 0, 1, 0, 0, 2'd0, 4'hF, 1), "setwin_eoi2");
      apply(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd0, 4'hF, 1), "setwin_quiet");

      // Reach SERVICE with source 3 still pending, then reset asynchronously mid-cycle.
      apply(mk(4'hC, 0, 0, 0, 1, 0, 0, 2'd0, 4'hF, 1), "svc_a");
      apply(mk(4'h0, 0, 0, 0, 2, 0, 0, 2'd0, 4'hF, 1), "svc_b");
      apply(mk(4'h0, 0, 0, 0, 1, 1, 1, 2'd2, 4'hF, 1), "svc_req");
      apply(mk(4'h0, 1, AA, 0, 1, 0, 1, 2'd2, 4'hF, 1), "svc_ack");
      #1;
      wr_en   = 1'b0;
      irq_src = 4'hF;
      rst_n   = 1'b0;
      #1;
      sb_q.push_back(ex(0, 0, 2'd0, 4'h0, 0));
      check("async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Levels already high at reset release are not edges; pre-reset pending is gone.
      apply(mk(4'hF, 1, MA, 32'hF, 1, 0, 0, 2'd0, 4'hF, 0), "lvl_mask");
      apply(mk(4'hF, 0, 0, 0, 8, 0, 0, 2'd0, 4'hF, 0), "lvl_hold");
      apply(mk(4'h0, 0, 0, 0, 3, 0, 0, 2'd0, 4'hF, 0), "lvl_low");
      apply(mk(4'h8, 0, 0, 0, 3, 0, 0, 2'd0, 4'hF, 0), "lvl_edge");
      apply(mk(4'h8, 0, 0, 0, 1, 1, 1, 2'd3, 4'hF, 0), "lvl_req");
      apply(mk(4'h8, 1, AA, 0, 1, 0, 1, 2'd3, 4'hF, 0), "lvl_ack");
      apply(mk(4'h8, 1, EA, 0, 1, 0, 0, 2'd3, 4'hF, 0), "lvl_eoi");
      apply(mk(4'h8, 0, 0, 0, 3, 0, 0, 2'd3, 4'hF, 0), "lvl_steady");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
